// File: rtl/fp_align_shifter.sv
// fp_align_shifter: two-stage operand alignment for floating-point addition.
// Stage 1 orders the operands and computes the exponent difference; stage 2
// right-shifts the smaller significand and appends guard/round/sticky bits.
// Optional feature macro: FP_ALIGN_STICKY_EN (sticky-bit generation).
module fp_align_shifter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   swap,
  output logic                   sign_big,
  output logic                   sign_small,
  output logic [EXP_W-1:0]       exp_big,
  output logic [MAN_W:0]         sig_big,
  output logic [MAN_W+3:0]       sig_small
);

  localparam int SIG_W = MAN_W + 1;
  localparam int SH_W  = MAN_W + 4;
  localparam logic [EXP_W-1:0] SH_LIM = EXP_W'(SH_W);
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

  // unpacked operand fields
  logic [EXP_W-1:0] exp_a_f, exp_b_f, eff_a, eff_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic [SIG_W-1:0] full_a, full_b;
  logic             swap_in;

  // handshake enables
  logic s1_load, s2_load;

  // stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_swap_q, s1_swap_d;
  logic             s1_sign_big_q, s1_sign_big_d;
  logic             s1_sign_small_q, s1_sign_small_d;
  logic [EXP_W-1:0] s1_exp_big_q, s1_exp_big_d;
  logic [SIG_W-1:0] s1_sig_big_q, s1_sig_big_d;
  logic [SIG_W-1:0] s1_sig_small_q, s1_sig_small_d;
  logic [EXP_W-1:0] s1_shift_q, s1_shift_d;

  // stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic             s2_swap_q, s2_swap_d;
  logic             s2_sign_big_q, s2_sign_big_d;
  logic             s2_sign_small_q, s2_sign_small_d;
  logic [EXP_W-1:0] s2_exp_big_q, s2_exp_big_d;
  logic [SIG_W-1:0] s2_sig_big_q, s2_sig_big_d;
  logic [SH_W-1:0]  s2_sig_small_q, s2_sig_small_d;

  // shifter datapath
  logic [EXP_W-1:0] shift_sat;
  logic [SH_W-1:0]  ext_small, shifted, low_mask, aligned;

  // Unpack both operands and decide which one is larger in magnitude.
  always_comb begin
    exp_a_f = a[EXP_W+MAN_W-1:MAN_W];
    exp_b_f = b[EXP_W+MAN_W-1:MAN_W];
    frac_a  = a[MAN_W-1:0];
    frac_b  = b[MAN_W-1:0];
    eff_a   = (exp_a_f == '0) ? EXP_ONE : exp_a_f;
    eff_b   = (exp_b_f == '0) ? EXP_ONE : exp_b_f;
    full_a  = {(exp_a_f != '0), frac_a};
    full_b  = {(exp_b_f != '0), frac_b};
    swap_in = (exp_b_f > exp_a_f) || ((exp_b_f == exp_a_f) && (frac_b > frac_a));
  end

  // A stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    s2_load = !s2_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
  end

  assign in_ready = s1_load;

  // Stage 1 next state: capture ordering and exponent difference on accept.
  always_comb begin
    s1_valid_d      = s1_valid_q;
    s1_swap_d       = s1_swap_q;
    s1_sign_big_d   = s1_sign_big_q;
    s1_sign_small_d = s1_sign_small_q;
    s1_exp_big_d    = s1_exp_big_q;
    s1_sig_big_d    = s1_sig_big_q;
    s1_sig_small_d  = s1_sig_small_q;
    s1_shift_d      = s1_shift_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
    end
    if (s1_load && in_valid) begin
      s1_swap_d = swap_in;
      if (swap_in) begin
        s1_sign_big_d   = b[EXP_W+MAN_W];
        s1_sign_small_d = a[EXP_W+MAN_W];
        s1_exp_big_d    = eff_b;
        s1_sig_big_d    = full_b;
        s1_sig_small_d  = full_a;
        s1_shift_d      = eff_b - eff_a;
      end else begin
        s1_sign_big_d   = a[EXP_W+MAN_W];
        s1_sign_small_d = b[EXP_W+MAN_W];
        s1_exp_big_d    = eff_a;
        s1_sig_big_d    = full_a;
        s1_sig_small_d  = full_b;
        s1_shift_d      = eff_a - eff_b;
      end
    end
  end

  // Right-shift the smaller significand; large differences saturate to a full flush.
  always_comb begin
    shift_sat = (s1_shift_q > SH_LIM) ? SH_LIM : s1_shift_q;
    ext_small = {s1_sig_small_q, 3'b000};
    shifted   = ext_small >> shift_sat;
    low_mask  = ~({SH_W{1'b1}} << shift_sat);
`ifdef FP_ALIGN_STICKY_EN
    aligned   = {shifted[SH_W-1:1], shifted[0] | (|(ext_small & low_mask))};
`else
    aligned   = {shifted[SH_W-1:1], 1'b0 & (|low_mask)};
`endif
  end

  // Stage 2 next state: take the aligned result when stage 2 can advance.
  always_comb begin
    s2_valid_d      = s2_valid_q;
    s2_swap_d       = s2_swap_q;
    s2_sign_big_d   = s2_sign_big_q;
    s2_sign_small_d = s2_sign_small_q;
    s2_exp_big_d    = s2_exp_big_q;
    s2_sig_big_d    = s2_sig_big_q;
    s2_sig_small_d  = s2_sig_small_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
    end
    if (s2_load && s1_valid_q) begin
      s2_swap_d       = s1_swap_q;
      s2_sign_big_d   = s1_sign_big_q;
      s2_sign_small_d = s1_sign_small_q;
      s2_exp_big_d    = s1_exp_big_q;
      s2_sig_big_d    = s1_sig_big_q;
      s2_sig_small_d  = aligned;
    end
  end

  // Pipeline registers; reset flushes both stages and clears all data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q      <= 1'b0;
      s1_swap_q       <= 1'b0;
      s1_sign_big_q   <= 1'b0;
      s1_sign_small_q <= 1'b0;
      s1_exp_big_q    <= '0;
      s1_sig_big_q    <= '0;
      s1_sig_small_q  <= '0;
      s1_shift_q      <= '0;
      s2_valid_q      <= 1'b0;
      s2_swap_q       <= 1'b0;
      s2_sign_big_q   <= 1'b0;
      s2_sign_small_q <= 1'b0;
      s2_exp_big_q    <= '0;
      s2_sig_big_q    <= '0;
      s2_sig_small_q  <= '0;
    end else begin
      s1_valid_q      <= s1_valid_d;
      s1_swap_q       <= s1_swap_d;
      s1_sign_big_q   <= s1_sign_big_d;
      s1_sign_small_q <= s1_sign_small_d;
      s1_exp_big_q    <= s1_exp_big_d;
      s1_sig_big_q    <= s1_sig_big_d;
      s1_sig_small_q  <= s1_sig_small_d;
      s1_shift_q      <= s1_shift_d;
      s2_valid_q      <= s2_valid_d;
      s2_swap_q       <= s2_swap_d;
      s2_sign_big_q   <= s2_sign_big_d;
      s2_sign_small_q <= s2_sign_small_d;
      s2_exp_big_q    <= s2_exp_big_d;
      s2_sig_big_q    <= s2_sig_big_d;
      s2_sig_small_q  <= s2_sig_small_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign swap       = s2_swap_q;
  assign sign_big   = s2_sign_big_q;
  assign sign_small = s2_sign_small_q;
  assign exp_big    = s2_exp_big_q;
  assign sig_big    = s2_sig_big_q;
  assign sig_small  = s2_sig_small_q;

endmodule

// File: tb/tb_fp_align_shifter.sv
// tb_fp_align_shifter: directed vectors for fp_align_shifter.
// Expected results are hand-computed; sticky expectations follow FP_ALIGN_STICKY_EN.
module tb_fp_align_shifter;

`ifdef FP_ALIGN_STICKY_EN
  localparam logic STK = 1'b1;
`else
  localparam logic STK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic        swap, sign_big, sign_small;
  logic [7:0]  exp_big;
  logic [23:0] sig_big;
  logic [26:0] sig_small;
  logic [61:0] obs;

  int vectors = 0;
  int miscompares = 0;

  // operand table and packed expected results {swap,sign_big,sign_small,exp,sig_big,sig_small}
  logic [31:0] va [11];
  logic [31:0] vb [11];
  logic [61:0] vexp [11];

  fp_align_shifter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .swap(swap), .sign_big(sign_big), .sign_small(sign_small),
    .exp_big(exp_big), .sig_big(sig_big), .sig_small(sig_small)
  );

  always #5 clk = ~clk;

  assign obs = {swap, sign_big, sign_small, exp_big, sig_big, sig_small};

  task automatic fill_table();
    va[0]  = 32'h40000000; vb[0]  = 32'h3F800000; vexp[0]  = {3'b000, 8'h80, 24'h800000, 27'h2000000};
    va[1]  = 32'h3F800000; vb[1]  = 32'hC1200000; vexp[1]  = {3'b110, 8'h82, 24'hA00000, 27'h0800000};
    va[2]  = 32'h3F800000; vb[2]  = 32'h3F800000; vexp[2]  = {3'b000, 8'h7F, 24'h800000, 27'h4000000};
    va[3]  = 32'h4D000000; vb[3]  = 32'h3F800001; vexp[3]  = {3'b000, 8'h9A, 24'h800000, {26'h0, STK}};
    va[4]  = 32'h7F800000; vb[4]  = 32'h3F800000; vexp[4]  = {3'b000, 8'hFF, 24'h800000, {26'h0, STK}};
    va[5]  = 32'h00000001; vb[5]  = 32'h00000000; vexp[5]  = {3'b000, 8'h01, 24'h000001, 27'h0000000};
    va[6]  = 32'h00400000; vb[6]  = 32'h00800000; vexp[6]  = {3'b100, 8'h01, 24'h800000, 27'h2000000};
    va[7]  = 32'h40800000; vb[7]  = 32'h3F800003; vexp[7]  = {3'b000, 8'h81, 24'h800000, 27'h1000006};
    va[8]  = 32'h41800000; vb[8]  = 32'h3F800003; vexp[8]  = {3'b000, 8'h83, 24'h800000, {26'h200000, STK}};
    va[9]  = 32'hBF800000; vb[9]  = 32'h3F800000; vexp[9]  = {3'b010, 8'h7F, 24'h800000, 27'h4000000};
    va[10] = 32'h7FC00000; vb[10] = 32'hFFC00001; vexp[10] = {3'b110, 8'hFF, 24'hC00001, 27'h6000000};
  endtask

  // reset state: flushed pipeline, zeroed outputs, ready to accept
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++;
    if (obs !== 62'h0) begin miscompares++; $display("[TB] FAIL reset_data got %h want 0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one pair at a time: latency of exactly two cycles and aligned values
  task automatic test_directed();
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = va[i]; b = vb[i];
      @(negedge clk);
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL early_valid vec %0d got %b want 0", i, out_valid); end
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || obs !== vexp[i]) begin
        miscompares++;
        $display("[TB] FAIL directed vec %0d valid %b data %h want valid 1 data %h", i, out_valid, obs, vexp[i]);
      end
    end
  endtask

  // four pairs on consecutive cycles with a free-running consumer
  task automatic test_throughput();
    int ord [4] = '{0, 1, 2, 7};
    logic want_valid;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      want_valid = (k >= 2) && (k <= 5);
      vectors++;
      if (out_valid !== want_valid || in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL thru_valid cycle %0d valid %b ready %b want valid %b ready 1", k, out_valid, in_ready, want_valid);
      end
      if (want_valid) begin
        vectors++;
        if (obs !== vexp[ord[k-2]]) begin
          miscompares++;
          $display("[TB] FAIL thru_data cycle %0d got %h want %h", k, obs, vexp[ord[k-2]]);
        end
      end
      in_valid = (k < 4);
      if (k < 4) begin a = va[ord[k]]; b = vb[ord[k]]; end
    end
    in_valid = 1'b0;
  endtask

  // back-to-back pairs against a stalled consumer, then drain in order
  task automatic test_back_to_back();
    int ord [4] = '{0, 1, 9, 7};
    int idx = 0;
    int oidx = 0;
    logic saw_block = 1'b0;
    logic have_hold = 1'b0;
    logic [61:0] held = '0;
    for (int cyc = 0; cyc < 40 && oidx < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid = (idx < 4);
      if (idx < 4) begin a = va[ord[idx]]; b = vb[ord[idx]]; end
      #1;
      if (in_valid && !in_ready) saw_block = 1'b1;
      if (have_hold) begin
        vectors++;
        if (out_valid !== 1'b1 || obs !== held) begin
          miscompares++;
          $display("[TB] FAIL stall_hold cycle %0d valid %b data %h want valid 1 data %h", cyc, out_valid, obs, held);
        end
      end
      if (out_valid && !out_ready) begin held = obs; have_hold = 1'b1; end
      else have_hold = 1'b0;
      if (out_valid && out_ready) begin
        vectors++;
        if (obs !== vexp[ord[oidx]]) begin
          miscompares++;
          $display("[TB] FAIL order result %0d got %h want %h", oidx, obs, vexp[ord[oidx]]);
        end
        oidx++;
      end
      if (in_valid && in_ready) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (saw_block !== 1'b1) begin miscompares++; $display("[TB] FAIL in_ready_block got %b want 1", saw_block); end
    vectors++;
    if (oidx != 4) begin miscompares++; $display("[TB] FAIL delivered_count got %0d want 4", oidx); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL duplicate got valid %b want 0", out_valid); end
  endtask

  // reset while a result is pending, then first accept right after release
  task automatic test_reset_midflight();
    logic stale = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; a = va[1]; b = vb[1];
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL pre_reset_valid got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || obs !== 62'h0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL async_reset valid %b data %h ready %b want 0 0 1", out_valid, obs, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    vectors++;
    if (stale !== 1'b0) begin miscompares++; $display("[TB] FAIL stale_after_reset got %b want 0", stale); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; a = va[0]; b = vb[0];
    @(negedge clk);
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL first_accept_early got %b want 0", out_valid); end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || obs !== vexp[0]) begin
      miscompares++;
      $display("[TB] FAIL first_accept valid %b data %h want 1 %h", out_valid, obs, vexp[0]);
    end
  endtask

  // run every scenario in order and report
  initial begin
    fill_table();
    test_reset();
    test_directed();
    test_throughput();
    test_back_to_back();
    test_reset_midflight();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
